reaction_game_ctrl: RTL
=======================

# reaction_game_ctrl

Sequencer for the Basys3 reaction-timer game. It waits a pseudo-random delay, then lights the stimulus LED and measures the player's reaction time in milliseconds. It detects false starts and timeouts, and keeps the best time since reset. It sits between the debounced pushbuttons and the BCD/7-segment display path, which takes its `ms_count`/`best_ms` outputs as binary values (0-9999).

## Interface
Parameters:
- `TICK_DIV`, default 100000: clk cycles per millisecond tick; 100 MHz clock gives 1 ms.
- `MIN_DELAY_MS`, default 1000: minimum random wait before the stimulus.
- `RAND_BITS`, default 11: number of LFSR bits added to the minimum; the random span is 0..2^RAND_BITS-1 ms.
- `TIMEOUT_MS`, default 9999: reaction count at which a round is abandoned.

Ports:
- `clk`, in, 1: system clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start_btn`, in, 1: debounced level; its rising edge starts a round.
- `react_btn`, in, 1: debounced level; its rising edge is the player's response.
- `stim_led`, out, 1: stimulus LED; high only in RUN.
- `ms_count`, out, 14: current or last reaction time in ms.
- `best_ms`, out, 14: best valid time since reset.
- `state`, out, 3: IDLE=0, WAIT=1, RUN=2, DONE=3, FOUL=4.
- `result_valid`, out, 1: one-cycle pulse on entry to DONE with a valid (non-timeout) time.
- `timeout`, out, 1: level; set on a timeout DONE, cleared on the next start.
- `false_start`, out, 1: level; high while in FOUL.

## Operation
- Button edges: each button is registered once; `rise = btn & ~btn_q`. Only rising edges act, so a held button never retriggers.
- LFSR: 16 bits, taps x^16+x^14+x^13+x^11+1. Seeded 16'hACE1 on reset and advanced every clk cycle. It is never zero.
- Ms prescaler: counts 0..TICK_DIV-1. It emits a one-cycle `tick` when the count equals TICK_DIV-1. It is cleared to 0 in the cycle a transition into WAIT or RUN is taken.
- IDLE: outputs hold. A start rise loads `delay_ms = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]` and clears `ms_count` and `timeout`, then goes to WAIT.
- WAIT: each tick decrements `delay_ms`.
  - A tick with `delay_ms == 1` goes to RUN, sets `stim_led=1` and `ms_count=0`.
  - A react rise goes to FOUL. This takes priority over a same-cycle tick.
  - A start rise is ignored.
- RUN: each tick increments `ms_count`.
  - A react rise goes to DONE: `stim_led=0`, `ms_count` frozen, `result_valid` pulses. If `ms_count < best_ms`, then `best_ms <= ms_count` in the same cycle.
  - A react rise and a tick in the same cycle: react wins and `ms_count` is not incremented.
  - If a tick would take `ms_count` to TIMEOUT_MS, `ms_count` is set to TIMEOUT_MS and the FSM goes to DONE with `timeout=1`. There is no `result_valid` and no best update.
  - A start rise is ignored.
- DONE and FOUL: a start rise behaves exactly as in IDLE and begins a new round. A react rise is ignored.
- Arithmetic: all counts are unsigned 14-bit. `ms_count` never exceeds TIMEOUT_MS, and `delay_ms` never underflows.
- A reaction of 0 ms (react rise before the first RUN tick) is valid and becomes the best time.

## Timing
- Reset values: state=IDLE, `stim_led=0`, `ms_count=0`, `best_ms=TIMEOUT_MS`, `result_valid=0`, `timeout=0`, `false_start=0`, prescaler=0, LFSR=16'hACE1.
- Reset asserted mid-round aborts the round on the next edge. All outputs return to their reset values, including `best_ms`.
- Button-to-state latency: a button level change becomes a rise one cycle later. `state` changes on the edge after that, for 2 cycles total.
- WAIT-to-RUN: the transition occurs on the edge of the delay_ms-th tick after WAIT entry, i.e. `delay_ms*TICK_DIV` cycles after entry.
- `ms_count` increments exactly once every TICK_DIV cycles in RUN, counting from RUN entry.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Test plan
Bench parameters: TICK_DIV=4, MIN_DELAY_MS=3, RAND_BITS=2, TIMEOUT_MS=20.
- Normal round:
  - Stimulus: reset; start rise; await RUN; react rise after 5 ticks.
  - Required: state 0→1→2→3; `stim_led` high only in RUN; `ms_count=5`; one `result_valid` pulse; `best_ms=5`.
- Best tracking:
  - Stimulus: rounds of 7, 3, then 9 ms.
  - Required: `best_ms` goes 20→7→3 and stays 3 after the 9 ms round.
- False start:
  - Stimulus: react rise during WAIT.
  - Required: state=4, `false_start=1`, `stim_led` never high, `best_ms` unchanged. A following start rise re-enters WAIT with `false_start=0`.
- Timeout:
  - Stimulus: no react in RUN.
  - Required: after 20 ticks, state=3, `ms_count=20`, `timeout=1`, no `result_valid`, `best_ms` unchanged.
- Simultaneous and ignored events:
  - React rise in the same cycle as a RUN tick: `ms_count` not incremented.
  - Start rise during WAIT or RUN: no effect.
  - React held high from before start: no false start (no rise).
- Delay range and reset:
  - Delay range: over 50 rounds, WAIT duration in ticks is within 3..6.
  - Reset pulsed during RUN: next cycle state=0, `stim_led=0`, `best_ms=20`.

Source files
------------

// File: rtl/reaction_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reaction_game_ctrl
// Purpose  : Sequencer for the reaction-timer game. Waits a pseudo-random
//            delay, lights the stimulus LED, then measures the player's
//            reaction time in milliseconds. Detects false starts and
//            timeouts and keeps the best valid time since reset.
// Ports    : clk           - system clock, rising edge
//            reset         - synchronous, active-high
//            start_btn     - debounced level, rising edge starts a round
//            react_btn     - debounced level, rising edge is the response
//            stim_led      - stimulus LED, high only while running
//            ms_count[13:0]- current or last reaction time (ms)
//            best_ms[13:0] - best valid time since reset (ms)
//            state[2:0]    - IDLE=0 WAIT=1 RUN=2 DONE=3 FOUL=4
//            result_valid  - one-cycle pulse on a valid (non-timeout) result
//            timeout       - level, set on a timeout, cleared on next start
//            false_start   - level, high while in FOUL
// Revision : 1.0 - initial release
// ============================================================================
module reaction_game_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        react_btn,
    output logic        stim_led,
    output logic [13:0] ms_count,
    output logic [13:0] best_ms,
    output logic [2:0]  state,
    output logic        result_valid,
    output logic        timeout,
    output logic        false_start
);

    localparam int              PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   c_tick_last = PW'(TICK_DIV - 1);
    localparam logic [13:0]     c_min_delay = 14'(MIN_DELAY_MS);
    localparam logic [13:0]     c_timeout   = 14'(TIMEOUT_MS);
    localparam logic [15:0]     c_lfsr_seed = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_FOUL = 3'd4
    } state_t;

    // Button capture: one input register, plus a delayed copy for edge detection
    logic        r_start_sync, r_start_q;
    logic        r_react_sync, r_react_q;
    logic        w_start_rise, w_react_rise;

    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    logic [PW-1:0] r_presc;
    logic        w_tick;

    state_t      r_state, w_state_n;
    logic [13:0] r_delay, w_delay_n;
    logic [13:0] r_ms, w_ms_n;
    logic [13:0] r_best, w_best_n;
    logic        r_timeout, w_timeout_n;
    logic        r_rv, w_rv_n;
    logic        r_stim, r_foul;
    logic        w_presc_clr;
    logic [13:0] w_rand;

    assign w_start_rise = r_start_sync & ~r_start_q;
    assign w_react_rise = r_react_sync & ~r_react_q;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form; the seed is non-zero so
    // the register can never lock up at zero.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_rand    = 14'(r_lfsr[RAND_BITS-1:0]);

    assign w_tick = (r_presc == c_tick_last);

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_n   = r_state;
        w_delay_n   = r_delay;
        w_ms_n      = r_ms;
        w_best_n    = r_best;
        w_timeout_n = r_timeout;
        w_rv_n      = 1'b0;
        w_presc_clr = 1'b0;

        case (r_state)
            S_IDLE, S_DONE, S_FOUL: begin
                if (w_start_rise) begin
                    w_state_n   = S_WAIT;
                    w_delay_n   = c_min_delay + w_rand;
                    w_ms_n      = 14'd0;
                    w_timeout_n = 1'b0;
                    w_presc_clr = 1'b1;
                end
            end

            S_WAIT: begin
                // A press during the wait is a false start, even on a tick
                if (w_react_rise) begin
                    w_state_n = S_FOUL;
                end else if (w_tick) begin
                    // <= 1 rather than == 1 keeps a zero delay from wrapping
                    if (r_delay <= 14'd1) begin
                        w_state_n   = S_RUN;
                        w_delay_n   = 14'd0;
                        w_ms_n      = 14'd0;
                        w_presc_clr = 1'b1;
                    end else begin
                        w_delay_n = r_delay - 14'd1;
                    end
                end
            end

            S_RUN: begin
                // The response freezes the count before a same-cycle tick
                if (w_react_rise) begin
                    w_state_n = S_DONE;
                    w_rv_n    = 1'b1;
                    if (r_ms < r_best) begin
                        w_best_n = r_ms;
                    end
                end else if (w_tick) begin
                    if ((r_ms + 14'd1) >= c_timeout) begin
                        w_ms_n      = c_timeout;
                        w_state_n   = S_DONE;
                        w_timeout_n = 1'b1;
                    end else begin
                        w_ms_n = r_ms + 14'd1;
                    end
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_sync <= 1'b0;
            r_start_q    <= 1'b0;
            r_react_sync <= 1'b0;
            r_react_q    <= 1'b0;
            r_lfsr       <= c_lfsr_seed;
            r_presc      <= '0;
            r_state      <= S_IDLE;
            r_delay      <= 14'd0;
            r_ms         <= 14'd0;
            r_best       <= c_timeout;
            r_timeout    <= 1'b0;
            r_rv         <= 1'b0;
            r_stim       <= 1'b0;
            r_foul       <= 1'b0;
        end else begin
            r_start_sync <= start_btn;
            r_start_q    <= r_start_sync;
            r_react_sync <= react_btn;
            r_react_q    <= r_react_sync;
            r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};

            // Restarting on entry to WAIT/RUN aligns every tick to that entry
            if (w_presc_clr || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            r_state   <= w_state_n;
            r_delay   <= w_delay_n;
            r_ms      <= w_ms_n;
            r_best    <= w_best_n;
            r_timeout <= w_timeout_n;
            r_rv      <= w_rv_n;
            r_stim    <= (w_state_n == S_RUN);
            r_foul    <= (w_state_n == S_FOUL);
        end
    end

    assign state        = r_state;
    assign stim_led     = r_stim;
    assign ms_count     = r_ms;
    assign best_ms      = r_best;
    assign result_valid = r_rv;
    assign timeout      = r_timeout;
    assign false_start  = r_foul;

endmodule
`default_nettype wire
